// File: rtl/fixed3_reciprocal_pkg.sv
// Shared fixed-point math package: Q16.16 scalar and 3-vector types,
// format constants, the per-lane FSM state type and small sign/saturate helpers.
package fixed3_reciprocal_pkg;

    localparam int FIXED_WIDTH = 32;
    localparam int FIXED_FRAC  = 16;
    localparam logic [FIXED_WIDTH-1:0] FIXED_MAX = 32'h7FFF_FFFF;

    // The reciprocal of a Q16.16 value is 2^(2*FRAC) / r in raw units.
    localparam int DIVIDEND_EXP = 2 * FIXED_FRAC;
    // One quotient bit per iteration over the full (DIVIDEND_EXP+1)-bit dividend.
    localparam int DIV_ITERS    = DIVIDEND_EXP + 1;

    typedef logic signed [FIXED_WIDTH-1:0] Fixed;

    typedef struct packed {
        Fixed x;
        Fixed y;
        Fixed z;
    } Fixed3;

    typedef enum logic [1:0] {
        RS_IDLE = 2'd0,
        RS_DIV  = 2'd1,
        RS_FIN  = 2'd2
    } recip_state_e;

    // Unsigned magnitude; 0x80000000 maps to 2^31, which fits unsigned.
    function automatic logic [FIXED_WIDTH-1:0] fixed_mag(input Fixed r);
        return r[FIXED_WIDTH-1] ? FIXED_WIDTH'(-r) : FIXED_WIDTH'(r);
    endfunction

    // Clamp the 33-bit magnitude quotient to FIXED_MAX, then reapply the sign.
    // A negative clamp gives -FIXED_MAX (0x80000001), keeping the range symmetric.
    function automatic Fixed saturate_sign(input logic [DIVIDEND_EXP:0] quo,
                                           input logic neg);
        logic [FIXED_WIDTH-1:0] mag;
        mag = (quo > {1'b0, FIXED_MAX}) ? FIXED_MAX : quo[FIXED_WIDTH-1:0];
        return neg ? Fixed'(-mag) : Fixed'(mag);
    endfunction

endpackage

// File: rtl/fixed3_reciprocal_seq.sv
// Single-lane Q16.16 reciprocal: restoring divider of 2^32 by |r|,
// MSB first, one quotient bit per cycle, followed by saturation and sign.
// start_i is honoured only in RS_IDLE; done_o pulses for one cycle when
// result_o has just been updated.
module fixed_recip_seq
    import fixed3_reciprocal_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         start_i,
    input  Fixed         r_i,
    output Fixed         result_o,
    output logic         done_o,
    output recip_state_e state_o
);

    recip_state_e state_q, state_d;

    logic [5:0]              count_q, count_d;
    logic [FIXED_WIDTH-1:0]  divisor_q, divisor_d;
    logic                    neg_q, neg_d;
    logic [FIXED_WIDTH-1:0]  rem_q, rem_d;
    logic [DIVIDEND_EXP:0]   quo_q, quo_d;
    Fixed                    result_q, result_d;
    logic                    done_q, done_d;

    logic                    load_en, iter_en, fin_en;
    logic [FIXED_WIDTH:0]    rem_shift;
    logic                    ge;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= RS_IDLE;
        else         state_q <= state_d;
    end

    // Next state: accept a start while idle, run DIV_ITERS iterations, one FIN cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RS_IDLE: if (start_i) state_d = RS_DIV;
            RS_DIV:  if (count_q == 6'(DIV_ITERS - 1)) state_d = RS_FIN;
            RS_FIN:  state_d = RS_IDLE;
            default: state_d = RS_IDLE;
        endcase
    end

    // Datapath controls decoded from the current state.
    always_comb begin
        load_en = (state_q == RS_IDLE) && start_i;
        iter_en = (state_q == RS_DIV);
        fin_en  = (state_q == RS_FIN);
    end

    // Divider step and operand/result next-state.
    always_comb begin
        divisor_d = divisor_q;
        neg_d     = neg_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        count_d   = count_q;
        result_d  = result_q;
        done_d    = fin_en;
        // Dividend 2^32 has a single set bit, consumed on the first iteration.
        rem_shift = {rem_q, (count_q == 6'd0)};
        ge        = rem_shift >= {1'b0, divisor_q};
        if (load_en) begin
            divisor_d = fixed_mag(r_i);
            neg_d     = r_i[FIXED_WIDTH-1];
            rem_d     = '0;
            quo_d     = '0;
            count_d   = '0;
        end else if (iter_en) begin
            rem_d   = ge ? FIXED_WIDTH'(rem_shift - {1'b0, divisor_q})
                         : rem_shift[FIXED_WIDTH-1:0];
            quo_d   = {quo_q[DIVIDEND_EXP-1:0], ge};
            count_d = count_q + 6'd1;
        end
        if (fin_en) result_d = saturate_sign(quo_q, neg_q);
    end

    // Datapath registers; reset discards any division in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q   <= '0;
            divisor_q <= '0;
            neg_q     <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            divisor_q <= divisor_d;
            neg_q     <= neg_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign result_o = result_q;
    assign done_o   = done_q;
    assign state_o  = state_q;

endmodule

// File: rtl/fixed3_reciprocal.sv
// Component-wise reciprocal of a Q16.16 3-vector. Three identical lanes
// start on the same accepted strobe and finish together 34 cycles later.
module fixed3_reciprocal
    import fixed3_reciprocal_pkg::*;
(
    input  logic  clk,
    input  logic  resetn,
    input  logic  strobe,
    input  Fixed3 v,
    output logic  valid,
    output Fixed3 ov
);

    recip_state_e x_state, y_state, z_state;
    logic         x_done, y_done, z_done;
    Fixed         x_res, y_res, z_res;
    logic         accept;

    // A start is taken only when every lane is idle; otherwise it is dropped.
    assign accept = strobe && (x_state == RS_IDLE) && (y_state == RS_IDLE)
                           && (z_state == RS_IDLE);

    fixed_recip_seq u_x (
        .clk(clk), .resetn(resetn), .start_i(accept), .r_i(v.x),
        .result_o(x_res), .done_o(x_done), .state_o(x_state)
    );

    fixed_recip_seq u_y (
        .clk(clk), .resetn(resetn), .start_i(accept), .r_i(v.y),
        .result_o(y_res), .done_o(y_done), .state_o(y_state)
    );

    fixed_recip_seq u_z (
        .clk(clk), .resetn(resetn), .start_i(accept), .r_i(v.z),
        .result_o(z_res), .done_o(z_done), .state_o(z_state)
    );

    // Lane results are registered and held until the next FIN edge.
    assign valid = x_done & y_done & z_done;
    assign ov    = '{x: x_res, y: y_res, z: z_res};

endmodule

// File: tb/tb_fixed3_reciprocal.sv
// Bench for fixed3_reciprocal. Handshake model: strobe is accepted on a
// rising edge when the unit is idle; valid then pulses for one cycle on the
// 34th edge after acceptance and ov holds its value at all other times.
module tb_fixed3_reciprocal;
    import fixed3_reciprocal_pkg::*;

    logic  clk    = 1'b0;
    logic  resetn = 1'b0;
    logic  strobe = 1'b0;
    Fixed3 v      = '0;
    logic  valid;
    Fixed3 ov;

    fixed3_reciprocal dut (
        .clk(clk), .resetn(resetn), .strobe(strobe), .v(v),
        .valid(valid), .ov(ov)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [95:0] exp_q[$];
    int          edge_q[$];
    logic [95:0] last_exp  = '0;
    int          next_free = 0;
    int          checks    = 0;
    int          failures  = 0;

    task automatic check_eq(input string name, input logic [95:0] act,
                            input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: trunc(2^32 / |r|), clamp to 0x7FFFFFFF, negate for r < 0.
    function automatic Fixed recip_model(input Fixed r);
        longint mag, q;
        logic [63:0] qb;
        mag = (r < 0) ? -longint'(r) : longint'(r);
        if (mag == 0) q = 64'h7FFF_FFFF;
        else begin
            q = longint'(64'h1_0000_0000) / mag;
            if (q > 64'h7FFF_FFFF) q = 64'h7FFF_FFFF;
        end
        if (r < 0) q = -q;
        qb = q;
        return Fixed'(qb[31:0]);
    endfunction

    function automatic logic [95:0] model3(input Fixed3 a);
        Fixed3 r;
        r.x = recip_model(a.x);
        r.y = recip_model(a.y);
        r.z = recip_model(a.z);
        return r;
    endfunction

    // Called right after a rising edge with strobe high: decide acceptance.
    task automatic note_edge();
        if (resetn && cyc >= next_free) begin
            exp_q.push_back(model3(v));
            edge_q.push_back(cyc + 34);
            next_free = cyc + 35;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input Fixed3 val, input int ncyc);
        @(negedge clk);
        strobe = 1'b1;
        v      = val;
        repeat (ncyc) begin
            @(posedge clk);
            note_edge();
        end
        @(negedge clk);
        strobe = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        strobe = 1'b0;
        #1;
        check_eq("reset_valid", {95'd0, valid}, 96'd0);
        check_eq("reset_ov", ov, 96'd0);
        exp_q.delete();
        edge_q.delete();
        last_exp  = '0;
        next_free = 0;
        repeat (ncyc) @(negedge clk);
        #2;
        resetn = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (edge_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (edge_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d results still pending", edge_q.size());
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : mon
        int last_edge;
        if (resetn) begin
            last_edge = cyc - 1;
            if (edge_q.size() > 0 && edge_q[0] == last_edge) begin
                check_eq("valid_pulse", {95'd0, valid}, 96'd1);
                check_eq("ov_result", ov, exp_q[0]);
                last_exp = exp_q.pop_front();
                void'(edge_q.pop_front());
            end else begin
                check_eq("valid_quiet", {95'd0, valid}, 96'd0);
                check_eq("ov_hold", ov, last_exp);
            end
        end
    end

    function automatic Fixed rand_fixed();
        Fixed s;
        case ($urandom_range(0, 3))
            0: s = Fixed'($urandom);
            1: s = Fixed'($urandom_range(0, 15)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
            2: case ($urandom_range(0, 4))
                   0: s = 32'sh0000_0000;
                   1: s = 32'sh0000_0001;
                   2: s = -32'sh0000_0001;
                   3: s = 32'sh8000_0000;
                   default: s = 32'sh7FFF_FFFF;
               endcase
            default: s = Fixed'($urandom_range(1, 32'h30000)) *
                         (($urandom_range(0, 1) == 1) ? -1 : 1);
        endcase
        return s;
    endfunction

    // ---------------- stimulus ----------------
    initial begin : stim
        Fixed3 a;
        do_reset(3);

        // Basic vector (1.0, 2.0, -0.5).
        drive('{x: 32'sh0001_0000, y: 32'sh0002_0000, z: 32'shFFFF_8000}, 1);
        drain();

        // Truncation.
        drive('{x: 32'sh0003_0000, y: 32'sh0000_0003, z: 32'shFFFD_0000}, 1);
        drain();

        // Saturation and zero.
        drive('{x: 32'sh0000_0000, y: 32'sh0000_0001, z: 32'shFFFF_FFFE}, 1);
        drain();

        // Most negative input.
        drive('{x: 32'sh8000_0000, y: 32'sh7FFF_FFFF, z: 32'shFFFF_FFFF}, 1);
        drain();

        // Busy: strobes at +5 and +20 after acceptance are dropped.
        drive('{x: 32'sh0004_0000, y: 32'sh0000_0100, z: 32'shFFF0_0000}, 1);
        idle_cycles(3);
        drive('{x: 32'sh0000_0007, y: 32'sh0000_0009, z: 32'sh0000_000B}, 1);
        idle_cycles(13);
        drive('{x: 32'sh0100_0000, y: 32'sh0000_0002, z: 32'sh0000_0005}, 1);
        drain();

        // Operand hold: v changes on the cycle after acceptance.
        drive('{x: 32'sh0000_0700, y: 32'shFFFF_0001, z: 32'sh1234_5678}, 1);
        v = '{x: Fixed'($urandom), y: Fixed'($urandom), z: Fixed'($urandom)};
        drain();

        // Strobe held continuously: accepts every 35 cycles.
        drive('{x: 32'sh0005_0000, y: 32'shFFFA_0000, z: 32'sh0000_0011}, 106);
        drain();

        // Reset in the middle of a division, then a fresh start.
        drive('{x: 32'sh0002_0000, y: 32'sh0002_0000, z: 32'sh0002_0000}, 1);
        idle_cycles(8);
        do_reset(2);
        idle_cycles(40);
        drive('{x: 32'sh0000_8000, y: 32'shFFFF_0000, z: 32'sh0000_0003}, 1);
        drain();

        // Randomized vectors.
        for (int i = 0; i < 10; i++) begin
            a.x = rand_fixed();
            a.y = rand_fixed();
            a.z = rand_fixed();
            drive(a, 1);
            drain();
        end

        idle_cycles(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run can never hang.
    initial begin : watchdog
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fixed3_reciprocal.md
# fixed3_reciprocal

Component-wise reciprocal unit for a three-element signed fixed-point vector. Each component x is replaced by 1/x, with sign handling and saturation. The ray pipeline uses it to turn a direction into an inverse direction for slab tests. Each computation is started by a single-cycle strobe and finishes with a single-cycle valid pulse after a fixed latency.

## Interface
Parameters:
- none. The format is fixed by the shared package: `Fixed` is a signed 32-bit Q16.16 value; `Fixed3` is a packed struct {x, y, z} of `Fixed`.

Ports:
- Reset resetn, asynchronous, active-low; clock clk.
- clk  input  1  clock; all state changes on its rising edge.
- resetn  input  1  asynchronous active-low reset.
- strobe  input  1  start request; sampled on a rising edge while idle.
- v  input  96 (`Fixed3`)  operand vector; captured on the accepting edge.
- valid  output  1  one-cycle pulse marking ov as newly updated.
- ov  output  96 (`Fixed3`)  result vector; holds until the next result.

## Operation
- Per component, the raw result is trunc(2^32 / |r|), where r is the raw 32-bit input. Truncation is toward zero in magnitude. The result is negated if r < 0.
- Saturation rules:
  - If the magnitude quotient exceeds 0x7FFFFFFF, the result is 0x7FFFFFFF for r > 0 and 0x80000001 (−0x7FFFFFFF) for r < 0.
  - r = 0 gives 0x7FFFFFFF.
  - r = 0x80000000 uses |r| = 2^31, so the quotient is 2 and the result is 0xFFFFFFFE.
- Datapath: an unsigned restoring divider per component.
  - Dividend is 2^32 (33 bits); divisor is |r| (32 bits, unsigned).
  - One quotient bit per cycle, 33 iterations, MSB first.
- Components are independent. All three start and finish together.
- States:
  - IDLE: valid=0. If strobe=1, capture v, latch three sign bits and magnitudes, clear remainders and quotients, load count=0, and go to DIV.
  - DIV: one iteration per edge. After the 33rd iteration, go to FIN.
  - FIN: apply saturation and sign, register ov, pulse valid=1, and return to IDLE.
- While the state is not IDLE, strobe is ignored. An ignored start is not queued.
- v is sampled only on the accepting edge. Later changes to v do not affect the computation in flight.

## Timing
- Edge E0 accepts strobe. Iterations run on edges E1–E33. Edge E34 registers ov and sets valid=1. Edge E35 clears valid.
- Latency is 34 cycles from the accepting edge to valid high. valid stays high for exactly 1 cycle.
- The unit is back in IDLE during the cycle valid is high. A strobe held high in that cycle is accepted on E35, so the minimum start-to-start spacing is 35 cycles.
- ov changes only on the FIN edge and is otherwise stable.
- Reset (any time, including mid-division): state=IDLE, valid=0, ov=0, and all internal registers are cleared. Any computation in flight is discarded and never produces a valid pulse.
- Reset release: the first strobe can be accepted on the first rising edge with resetn=1.

## Structure
- Shared package (math package): typedefs `Fixed` and `Fixed3`, and constants FIXED_WIDTH=32, FIXED_FRAC=16, FIXED_MAX=32'h7FFFFFFF.
- One sub-module, `fixed_recip_seq`, handles a single component. It contains the divider, sign handling and saturation, plus a start/done handshake.
- The top instantiates `fixed_recip_seq` three times with a shared FSM/counter, or uses the done output of the x instance. It also drives valid and ov.

## Test plan
- Basic vector: v=(0x00010000, 0x00020000, 0xFFFF8000), i.e. (1.0, 2.0, −0.5), strobe for 1 cycle.
  - Response: ov=(0x00010000, 0x00008000, 0xFFFE0000) with valid high 34 cycles after the accepting edge, for exactly 1 cycle.
- Truncation: v.x=0x00030000 (3.0) gives 0x00005555; v.y=0x00000003 gives 0x55555555; v.z=0xFFFD0000 (−3.0) gives 0xFFFFAAAB.
- Saturation: v=(0x00000000, 0x00000001, 0xFFFFFFFE) gives ov=(0x7FFFFFFF, 0x7FFFFFFF, 0x80000001).
  - Also apply v.x=0x80000000 and expect 0xFFFFFFFE.
- Busy behaviour:
  - A strobe with a new v at cycles 5 and 20 after acceptance is ignored; ov matches the first operand and exactly one valid pulse occurs.
  - A strobe held high continuously gives valid pulses every 35 cycles.
- Operand hold: changing v on the cycle after acceptance does not alter the result.
- Reset mid-operation: assert resetn=0 at cycle 10 of a division.
  - Response: valid=0 and ov=0 immediately, no valid pulse afterwards, and a fresh strobe after release gives a correct result at latency 34.
